// File: rtl/trig_pkg.sv
// Shared types and constants for the ADC trigger discriminator.
// Sample and counter widths, polarity codes and FSM state encoding.
package trig_pkg;
   localparam int unsigned SAMPLE_W = 14;
   localparam int unsigned CNT_W    = 16;

   localparam logic POL_RISING  = 1'b0;
   localparam logic POL_FALLING = 1'b1;

   typedef enum logic [2:0] {
      DISARMED,
      ARMED,
      CONFIRM,
      FIRE,
      HOLDOFF
   } trig_state_t;
endpackage

// File: rtl/adc_trigger_discriminator_if.sv
// Sample/config inputs and trigger/status outputs of the trigger discriminator.
// The master drives samples and configuration; the slave is the discriminator.
interface adc_trigger_discriminator_if;
   import trig_pkg::*;

   logic [SAMPLE_W-1:0] signal;
   logic [SAMPLE_W-1:0] threshold;
   logic [SAMPLE_W-1:0] hysteresis;
   logic                polarity;
   logic                enable;
   logic                triggerOut;
   logic                busy;
   logic [CNT_W-1:0]    triggerCount;
   logic [CNT_W-1:0]    missedCount;

   modport master (
      output signal, threshold, hysteresis, polarity, enable,
      input  triggerOut, busy, triggerCount, missedCount
   );

   modport slave (
      input  signal, threshold, hysteresis, polarity, enable,
      output triggerOut, busy, triggerCount, missedCount
   );
endinterface

// File: rtl/trig_level_compare.sv
// Combinational level compare: qualify and re-arm decisions for one sample.
// All arithmetic is one bit wider than the sample so nothing wraps.
module trig_level_compare
   import trig_pkg::*;
(
   input  logic [SAMPLE_W-1:0] sig_q,
   input  logic [SAMPLE_W-1:0] threshold,
   input  logic [SAMPLE_W-1:0] hysteresis,
   input  logic                polarity,
   output logic                qualify,
   output logic                rearm
);
   localparam logic [SAMPLE_W:0] SAMPLE_MAX = {1'b0, {SAMPLE_W{1'b1}}};

   logic [SAMPLE_W:0] s_w;
   logic [SAMPLE_W:0] t_w;
   logic [SAMPLE_W:0] h_w;
   logic [SAMPLE_W:0] low_lvl;
   logic [SAMPLE_W:0] high_lvl;

   assign s_w      = {1'b0, sig_q};
   assign t_w      = {1'b0, threshold};
   assign h_w      = {1'b0, hysteresis};
   assign low_lvl  = t_w - h_w;
   assign high_lvl = t_w + h_w;

   // An out-of-range re-arm level means the discriminator can never re-arm.
   always_comb begin
      qualify = 1'b0;
      rearm   = 1'b0;
      if (polarity == POL_RISING) begin
         qualify = (s_w >= t_w);
         rearm   = (t_w >= h_w) && (s_w < low_lvl);
      end else begin
         qualify = (s_w <= t_w);
         rearm   = (high_lvl <= SAMPLE_MAX) && (s_w > high_lvl);
      end
   end
endmodule

// File: rtl/adc_trigger_discriminator.sv
// ADC threshold trigger: hysteresis re-arm, N-sample confirmation, hold-off,
// single-cycle registered trigger pulse and accepted/missed statistics.
module adc_trigger_discriminator
   import trig_pkg::*;
#(
   parameter int unsigned CONFIRM_SAMPLES = 4,
   parameter int unsigned HOLDOFF_CYCLES  = 2000
) (
   input  logic                        clk,
   input  logic                        reset,
   adc_trigger_discriminator_if.slave  bus
);
   localparam int unsigned CONF_W = $clog2(CONFIRM_SAMPLES + 1);
   localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_SAMPLES);
   localparam logic [CONF_W-1:0] CONF_ONE  = CONF_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

   logic [SAMPLE_W-1:0] sig_q;
   logic                qualify;
   logic                rearm;
   logic                qual_q;

   trig_state_t         state;
   trig_state_t         state_nx;
   logic [CONF_W-1:0]   conf_cnt;
   logic [CONF_W-1:0]   conf_nx;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [HOLD_W-1:0]   hold_nx;

   logic                trig_q;
   logic                busy_q;
   logic [CNT_W-1:0]    trig_cnt;
   logic [CNT_W-1:0]    miss_cnt;

   trig_level_compare u_cmp (
      .sig_q      (sig_q),
      .threshold  (bus.threshold),
      .hysteresis (bus.hysteresis),
      .polarity   (bus.polarity),
      .qualify    (qualify),
      .rearm      (rearm)
   );

   // Terminal confirm count is tested before enable so a simultaneous
   // enable drop still lets the confirmed trigger fire.
   always_comb begin
      state_nx = state;
      conf_nx  = conf_cnt;
      hold_nx  = hold_cnt;
      unique case (state)
         DISARMED: begin
            conf_nx = '0;
            if (bus.enable && rearm) state_nx = ARMED;
         end
         ARMED: begin
            if (!bus.enable) begin
               state_nx = DISARMED;
               conf_nx  = '0;
            end else if (qualify) begin
               conf_nx  = CONF_ONE;
               state_nx = (CONFIRM_SAMPLES == 1) ? FIRE : CONFIRM;
            end
         end
         CONFIRM: begin
            if (conf_cnt == CONF_LAST) begin
               state_nx = FIRE;
               conf_nx  = '0;
            end else if (!bus.enable) begin
               state_nx = DISARMED;
               conf_nx  = '0;
            end else if (qualify) begin
               conf_nx  = conf_cnt + CONF_ONE;
            end else begin
               state_nx = ARMED;
               conf_nx  = '0;
            end
         end
         FIRE: begin
            state_nx = HOLDOFF;
            conf_nx  = '0;
            hold_nx  = '0;
         end
         HOLDOFF: begin
            if (hold_cnt == HOLD_LAST) begin
               state_nx = DISARMED;
               hold_nx  = '0;
            end else begin
               hold_nx  = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_nx = DISARMED;
            conf_nx  = '0;
            hold_nx  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sig_q    <= '0;
         qual_q   <= 1'b0;
         state    <= DISARMED;
         conf_cnt <= '0;
         hold_cnt <= '0;
         trig_q   <= 1'b0;
         busy_q   <= 1'b0;
         trig_cnt <= '0;
         miss_cnt <= '0;
      end else begin
         sig_q    <= bus.signal;
         qual_q   <= qualify;
         state    <= state_nx;
         conf_cnt <= conf_nx;
         hold_cnt <= hold_nx;
         // Outputs are registered from the next state so they align with it.
         trig_q   <= (state_nx == FIRE);
         busy_q   <= (state_nx == FIRE) || (state_nx == HOLDOFF);
         if (state_nx == FIRE) trig_cnt <= trig_cnt + 1'b1;
         if ((state == HOLDOFF) && qualify && !qual_q && (miss_cnt != '1))
            miss_cnt <= miss_cnt + 1'b1;
      end
   end

   assign bus.triggerOut   = trig_q;
   assign bus.busy         = busy_q;
   assign bus.triggerCount = trig_cnt;
   assign bus.missedCount  = miss_cnt;
endmodule

// File: tb/tb_adc_trigger_discriminator.sv
// Directed bench for adc_trigger_discriminator: stimulus pushes expected
// trigger pulses into a queue, a monitor pops and checks each observed pulse.
module tb_adc_trigger_discriminator;
   import trig_pkg::*;

   typedef struct {
      int unsigned cyc;
      logic [15:0] cnt;
   } exp_t;

   logic        clk;
   logic        reset;
   int unsigned cyc;
   int unsigned n_chk;
   int unsigned n_fail;
   int unsigned busy_run;
   int unsigned busy_len;
   exp_t        exp_q[$];

   adc_trigger_discriminator_if bus ();

   adc_trigger_discriminator #(
      .CONFIRM_SAMPLES (4),
      .HOLDOFF_CYCLES  (2000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Expected pulse: sample captured at the coming edge t, pulse follows edge t+5.
   task automatic expect_trigger(input logic [15:0] cnt);
      exp_t e;
      e.cyc = cyc + 6;
      e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   // Monitor: samples 2 time units after each rising edge
   initial begin
      exp_t e;
      busy_run = 0;
      busy_len = 0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.busy === 1'b1) busy_run++;
         else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
         end
         if (bus.triggerOut === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_trigger: got pulse at cycle %0d expected none", cyc);
            end else begin
               e = exp_q.pop_front();
               check("trig_cycle", cyc, e.cyc);
               check("trig_count", 32'(bus.triggerCount), 32'(e.cnt));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset          = 1'b1;
      bus.signal     = 14'd7000;
      bus.threshold  = 14'd8000;
      bus.hysteresis = 14'd100;
      bus.polarity   = POL_RISING;
      bus.enable     = 1'b1;
      wait_cyc(2);
      check("rst_trig",   32'(bus.triggerOut),   0);
      check("rst_busy",   32'(bus.busy),         0);
      check("rst_tcount", 32'(bus.triggerCount), 0);
      check("rst_mcount", 32'(bus.missedCount),  0);
      check("rst_state",  32'(dut.state),        32'(DISARMED));
      reset = 1'b0;
      wait_cyc(3);
      check("armed_init", 32'(dut.state), 32'(ARMED));

      // Glitch: three qualifying samples only
      bus.signal = 14'd8500;
      wait_cyc(3);
      bus.signal = 14'd7000;
      wait_cyc(6);
      check("glitch_state",  32'(dut.state),        32'(ARMED));
      check("glitch_tcount", 32'(bus.triggerCount), 0);
      check("glitch_mcount", 32'(bus.missedCount),  0);

      // Rising ramp
      bus.signal = 14'd7500;
      wait_cyc(1);
      bus.signal = 14'd8000;
      expect_trigger(16'd1);
      wait_cyc(1);
      bus.signal = 14'd8500;
      wait_cyc(1);
      bus.signal = 14'd9000;
      wait_cyc(20);
      check("ramp_tcount", 32'(bus.triggerCount), 1);
      check("ramp_busy",   32'(bus.busy),         1);

      // Second crossing inside hold-off
      bus.signal = 14'd7000;
      wait_cyc(460);
      bus.signal = 14'd9000;
      wait_cyc(10);
      check("holdoff_mcount", 32'(bus.missedCount),  1);
      check("holdoff_tcount", 32'(bus.triggerCount), 1);
      wait_cyc(2100);
      check("holdoff_done",  32'(bus.busy),  0);
      check("busy_len",      busy_len,       2001);
      check("post_hold_dis", 32'(dut.state), 32'(DISARMED));

      // Third crossing after re-arm
      bus.signal = 14'd7000;
      wait_cyc(3);
      check("rearm_rise", 32'(dut.state), 32'(ARMED));
      bus.signal = 14'd9000;
      expect_trigger(16'd2);
      wait_cyc(20);
      check("third_tcount", 32'(bus.triggerCount), 2);
      bus.signal = 14'd2000;
      wait_cyc(2100);
      check("rearm_after_hold", 32'(dut.state), 32'(ARMED));

      // Falling polarity
      bus.polarity   = POL_FALLING;
      bus.threshold  = 14'd1000;
      bus.hysteresis = 14'd50;
      wait_cyc(3);
      check("fall_armed", 32'(dut.state), 32'(ARMED));
      bus.signal = 14'd900;
      expect_trigger(16'd3);
      wait_cyc(2100);
      check("fall_tcount", 32'(bus.triggerCount), 3);
      check("fall_dis",    32'(dut.state),        32'(DISARMED));
      bus.signal = 14'd1040;
      wait_cyc(5);
      check("fall_no_rearm", 32'(dut.state), 32'(DISARMED));
      bus.signal = 14'd1051;
      wait_cyc(3);
      check("fall_rearm", 32'(dut.state), 32'(ARMED));
      check("fall_mcount", 32'(bus.missedCount), 1);

      // Edge cases: unreachable re-arm levels
      bus.enable = 1'b0;
      wait_cyc(2);
      check("disable_dis", 32'(dut.state), 32'(DISARMED));
      bus.polarity   = POL_RISING;
      bus.threshold  = 14'd50;
      bus.hysteresis = 14'd100;
      bus.signal     = 14'd0;
      bus.enable     = 1'b1;
      wait_cyc(5);
      bus.signal = 14'd60;
      wait_cyc(10);
      check("low_thr_never", 32'(dut.state), 32'(DISARMED));
      bus.polarity   = POL_FALLING;
      bus.threshold  = 14'd16383;
      bus.hysteresis = 14'd1;
      bus.signal     = 14'd16383;
      wait_cyc(5);
      bus.signal = 14'd0;
      wait_cyc(10);
      check("high_thr_never", 32'(dut.state), 32'(DISARMED));
      check("edge_tcount",    32'(bus.triggerCount), 3);

      // Enable dropped mid-confirm
      bus.polarity   = POL_RISING;
      bus.threshold  = 14'd8000;
      bus.hysteresis = 14'd100;
      bus.signal     = 14'd7000;
      wait_cyc(3);
      check("ena_armed", 32'(dut.state), 32'(ARMED));
      bus.signal = 14'd9000;
      wait_cyc(3);
      check("ena_confirm", 32'(dut.state), 32'(CONFIRM));
      bus.enable = 1'b0;
      @(posedge clk);
      #2;
      check("ena_drop_dis", 32'(dut.state), 32'(DISARMED));
      @(negedge clk);
      wait_cyc(10);
      check("ena_drop_tcount", 32'(bus.triggerCount), 3);

      // Reset during hold-off
      bus.enable = 1'b1;
      bus.signal = 14'd7000;
      wait_cyc(3);
      bus.signal = 14'd9000;
      expect_trigger(16'd4);
      wait_cyc(50);
      check("pre_rst_busy", 32'(bus.busy), 1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst_trig",   32'(bus.triggerOut),   0);
      check("mid_rst_busy",   32'(bus.busy),         0);
      check("mid_rst_tcount", 32'(bus.triggerCount), 0);
      check("mid_rst_mcount", 32'(bus.missedCount),  0);
      check("mid_rst_state",  32'(dut.state),        32'(DISARMED));
      @(negedge clk);
      reset = 1'b0;
      wait_cyc(5);
      check("pending_triggers", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
